// File: rtl/fp_add_issue_ctrl.sv
// Issue/collect controller around a fixed-latency, non-stallable FP adder.
// Credits (in-flight + stored results) bound issue so the result FIFO can never overflow.
module fp_add_issue_ctrl #(
    parameter int ADD_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic [CNT_W-1:0] fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADD_LATENCY:0] valid_pipe;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [31:0]          result_mem [FIFO_DEPTH];
    logic [CNT_W:0]       credit_used;
    logic                 accept;
    logic                 capture;
    logic                 pop;

    // Credit is taken from registered counts only, so a same-cycle pop frees nothing yet.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
    assign in_ready    = rst_n & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign accept      = in_valid & in_ready;
    assign capture     = valid_pipe[ADD_LATENCY];
    assign out_valid   = (fifo_cnt != '0);
    assign pop         = out_valid & out_ready;
    assign out_sum     = out_valid ? result_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_a        <= '0;
            add_b        <= '0;
            valid_pipe   <= '0;
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            // Idle cycles feed zero+zero so the adder produces nothing of interest.
            add_a      <= accept ? in_a : 32'd0;
            add_b      <= accept ? in_b : 32'd0;
            valid_pipe <= {valid_pipe[ADD_LATENCY-1:0], accept};

            case ({accept, capture})
                2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
                2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
                default: inflight_cnt <= inflight_cnt;
            endcase

            case ({capture, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            result_mem[wr_ptr] <= add_sum;
        end
    end

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// Bench for fp_add_issue_ctrl: behavioural 5-stage adder, scoreboard queue of
// expected sums checked as results leave the FIFO.
module tb_fp_add_issue_ctrl;

    localparam int ADD_LATENCY = 5;
    localparam int FIFO_DEPTH  = 8;
    localparam int CNT_W       = 4;
    localparam int LAT_TICKS   = ADD_LATENCY + 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] fifo_cnt;

    typedef struct {
        logic [31:0] sum;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks;
    int          errors;
    int          cyc;
    logic        check_lat;
    logic [31:0] adder_pipe [ADD_LATENCY];

    fp_add_issue_ctrl #(
        .ADD_LATENCY(ADD_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .inflight_cnt(inflight_cnt),
        .fifo_cnt    (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal numbers and signed zeros only; enough for the vectors used here.
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) d = {x[31], 63'd0};
        else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real2sp(sp2real(a) + sp2real(b));
    endfunction

    // Behavioural adder: result on add_sum ADD_LATENCY edges after operands appear.
    always @(posedge clk) begin
        adder_pipe[0] <= fp_add(add_a, add_b);
        for (int i = 1; i < ADD_LATENCY; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign add_sum = adder_pipe[ADD_LATENCY-1];

    // Scoreboard work happens at the falling edge, where handshakes for the next edge are stable.
    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
            end
            return;
        end
        if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_out: got %h with empty scoreboard", out_sum);
            end else begin
                e = sbq.pop_front();
                if (out_sum !== e.sum) begin
                    errors++;
                    $display("[TB] FAIL out_sum: got %h want %h", out_sum, e.sum);
                end
                if (check_lat) begin
                    checks++;
                    if (cyc - e.cyc != LAT_TICKS) begin
                        errors++;
                        $display("[TB] FAIL latency: got %0d want %0d", cyc - e.cyc, LAT_TICKS);
                    end
                end
            end
        end
        if (in_valid && in_ready) sbq.push_back('{sum: fp_add(in_a, in_b), cyc: cyc});
        if (32'(inflight_cnt) + 32'(fifo_cnt) > FIFO_DEPTH) begin
            errors++;
            $display("[TB] FAIL credit_overflow: got %0d want <= %0d",
                     32'(inflight_cnt) + 32'(fifo_cnt), FIFO_DEPTH);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((fifo_cnt != 0 || inflight_cnt != 0) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (fifo_cnt != 0 || inflight_cnt != 0 || sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got fifo=%0d inflight=%0d pending=%0d want 0/0/0",
                     fifo_cnt, inflight_cnt, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || out_valid !== 1'b0 || out_sum !== 32'd0 ||
            inflight_cnt !== '0 || fifo_cnt !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got a=%h b=%h ov=%b os=%h if=%0d fc=%0d rdy=%b want all 0",
                     add_a, add_b, out_valid, out_sum, inflight_cnt, fifo_cnt, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_op();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            checks++;
            if (out_valid !== (j == 6)) begin
                errors++;
                $display("[TB] FAIL single_out_valid: cycle %0d got %b want %b", j, out_valid, j == 6);
            end
        end
        checks++;
        if (out_sum !== 32'h40000000 || inflight_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL single_result: got sum=%h inflight=%0d want 40000000/0",
                     out_sum, inflight_cnt);
        end
        drain();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_a = 32'h3F800000 + (i << 20);
            in_b = 32'h3F000000;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 8) begin
            errors++;
            $display("[TB] FAIL bp_accepted: got %0d want 8", acc);
        end
        repeat (8) tick();
        checks++;
        if (fifo_cnt !== 4'd8 || inflight_cnt !== 4'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full: got fifo=%0d inflight=%0d rdy=%b want 8/0/0",
                     fifo_cnt, inflight_cnt, in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_same_cycle_credit: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_credit_return: got %b want 1", in_ready);
        end
        drain();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        out_ready = 1'b1;
        check_lat = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = 32'h40000000 + i;
            in_b = 32'h3F800000;
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("[TB] FAIL stream_stalls: got %0d want 0", stalls);
        end
        drain();
        check_lat = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 32'h00000000;
        in_b = 32'h40490FDB;
        tick();
        in_a = 32'hC0490FDB;
        in_b = 32'h00000000;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (out_sum !== 32'h40490FDB) begin
            errors++;
            $display("[TB] FAIL zero_first: got %h want 40490fdb", out_sum);
        end
        tick();
        checks++;
        if (out_sum !== 32'hC0490FDB) begin
            errors++;
            $display("[TB] FAIL zero_second: got %h want c0490fdb", out_sum);
        end
        drain();
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [31:0] vals [5];
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) vals[i] = fp_add(32'h41000000 + (i << 18), 32'h3F800000);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = 32'h41000000 + (i << 18);
            in_b = 32'h3F800000;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        checks++;
        if (fifo_cnt !== 4'd4 || out_sum !== vals[0]) begin
            errors++;
            $display("[TB] FAIL pp_setup: got fifo=%0d head=%h want 4/%h", fifo_cnt, out_sum, vals[0]);
        end
        in_valid = 1'b1;
        in_a = 32'h41000000 + (4 << 18);
        in_b = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (fifo_cnt !== 4'd4 || out_sum !== vals[1]) begin
            errors++;
            $display("[TB] FAIL pp_simultaneous: got fifo=%0d head=%h want 4/%h",
                     fifo_cnt, out_sum, vals[1]);
        end
        drain();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 32'h40400000 + (i << 20);
            in_b = 32'h3F800000;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 32'h40800000 + (i << 20);
            in_b = 32'h3F800000;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_cnt !== 4'd2 || inflight_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL mr_setup: got fifo=%0d inflight=%0d want 2/3", fifo_cnt, inflight_cnt);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_cnt !== '0 || inflight_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mr_after: got ov=%b fifo=%0d inflight=%0d rdy=%b want 0/0/0/1",
                     out_valid, fifo_cnt, inflight_cnt, in_ready);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || fifo_cnt !== '0) begin
                errors++;
                $display("[TB] FAIL mr_spurious: cycle %0d got ov=%b fifo=%0d want 0/0",
                         j, out_valid, fifo_cnt);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        check_lat = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        for (int i = 0; i < ADD_LATENCY; i++) adder_pipe[i] = '0;
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_zero();
        test_push_pop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
